// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (I) and data (D) requesters.
// Latency: request sampled at edge T -> mreq in cycle T+1 -> ready pulse in cycle T+1+WAIT.
// Backpressure: requesters hold req until their ready pulse; requests outside IDLE wait.
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic          iready,
  output logic [DW-1:0] irdata,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic          dready,
  output logic [DW-1:0] drdata,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAITM, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          own_q;      // 0 = fetch side, 1 = data side
  logic          last_d_q;   // previous completed access belonged to the data side
  logic          we_q;       // owner's access is a write
  logic          mreq_q;
  logic          mwe_q;
  logic [AW-1:0] maddr_q;
  logic [DW-1:0] mwdata_q;
  logic          iready_q;
  logic          dready_q;
  logic [DW-1:0] irdata_q;
  logic [DW-1:0] drdata_q;
  logic          pick_d;
  logic          pick_i;

  // Data side wins unless it just completed while fetch is waiting.
  always_comb begin
    pick_d = dreq && (!last_d_q || !ireq);
    pick_i = !pick_d && ireq;
  end

  // Access sequencer with registered memory strobes and completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      own_q    <= 1'b0;
      last_d_q <= 1'b0;
      we_q     <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      // Memory strobes and ready pulses last exactly one cycle.
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            own_q    <= 1'b1;
            we_q     <= dwe;
            mreq_q   <= 1'b1;
            mwe_q    <= dwe;
            maddr_q  <= daddr;
            mwdata_q <= dwdata;
            state_q  <= ISSUE;
          end else if (pick_i) begin
            own_q    <= 1'b0;
            we_q     <= 1'b0;
            mreq_q   <= 1'b1;
            maddr_q  <= iaddr;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= CNT_INIT;
          if (WAIT == 1) begin
            iready_q <= !own_q;
            dready_q <= own_q;
            state_q  <= DONE;
          end else begin
            state_q  <= WAITM;
          end
        end
        WAITM: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            iready_q <= !own_q;
            dready_q <= own_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // mrdata is valid this cycle; keep it for the owner until its next completion.
          if (own_q) begin
            if (!we_q) drdata_q <= mrdata;
          end else begin
            irdata_q <= mrdata;
          end
          last_d_q <= own_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data bypasses the holding register during the completion cycle.
  always_comb begin
    irdata = iready_q ? mrdata : irdata_q;
    drdata = (dready_q && !we_q) ? mrdata : drdata_q;
  end

  assign iready = iready_q;
  assign dready = dready_q;
  assign mreq   = mreq_q;
  assign mwe    = mwe_q;
  assign maddr  = maddr_q;
  assign mwdata = mwdata_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a WAIT=2 instance checked every cycle against a
// transaction-level model, plus a WAIT=1 instance for the single-wait path.
// Directed scenarios carry hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  logic [31:0] mrdata = 32'h0;
  logic        iready, dready, mreq, mwe, busy;
  logic [31:0] irdata, drdata, maddr, mwdata;

  logic        ireq1 = 1'b0, dwe1 = 1'b0, dreq1;
  logic [31:0] iaddr1 = 32'h0, dwdata1 = 32'h0, daddr1;
  logic [31:0] mrdata1 = 32'h0;
  logic        iready1, dready1, mreq1, mwe1, busy1;
  logic [31:0] irdata1, drdata1, maddr1, mwdata1;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(W2)) u_dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .iready(iready), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dready(dready), .drdata(drdata),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mrdata(mrdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .ireq(ireq1), .iaddr(iaddr1), .iready(iready1), .irdata(irdata1),
    .dreq(dreq1), .dwe(dwe1), .daddr(daddr1), .dwdata(dwdata1),
    .dready(dready1), .drdata(drdata1),
    .mreq(mreq1), .mwe(mwe1), .maddr(maddr1), .mwdata(mwdata1),
    .mrdata(mrdata1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: environment copy (answers the DUT) and the model's own copy.
  logic [31:0] env_mem   [0:255];
  logic [31:0] model_mem [0:255];
  initial begin
    for (int a = 0; a < 256; a++) begin
      env_mem[a]   = 32'hA500_0000 | 32'(a << 2);
      model_mem[a] = 32'hA500_0000 | 32'(a << 2);
    end
    env_mem[16]   = 32'h8C01_0004;
    model_mem[16] = 32'h8C01_0004;
  end

  // Cycle counter, memory environment and transaction model, all stepped at the edge.
  int          cyc = 0;
  int          rd_cyc = -10;
  logic [31:0] rd_val = 32'h0;
  int          m_issue = -100, m_done = -100;
  bit          m_own = 1'b0, m_we = 1'b0, m_lastd = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdval = 32'h0;
  logic [31:0] m_ihold = 32'h0, m_dhold = 32'h0;

  always @(posedge clk) begin
    int k;
    bit was_idle;
    cyc = cyc + 1;
    k = cyc;
    // Memory environment: react to a strobe seen in the previous cycle.
    if (mreq) begin
      if (mwe) env_mem[maddr[9:2]] = mwdata;
      else begin
        rd_cyc = k - 1 + W2;
        rd_val = env_mem[maddr[9:2]];
      end
    end
    if (k == rd_cyc) mrdata <= rd_val;
    else             mrdata <= {16'hBAD0, cyc[15:0]};
    // Model: an access occupies cycles issue..issue+WAIT, followed by one idle cycle.
    if (!reset) begin
      m_issue = -100; m_done = -100; m_lastd = 1'b0;
      m_ihold = 32'h0; m_dhold = 32'h0;
    end else begin
      if (m_done == k - 1) begin
        if (m_own) begin
          if (!m_we) m_dhold = m_rdval;
        end else begin
          m_ihold = m_rdval;
        end
        m_lastd = m_own;
      end
      was_idle = (k - 1 > m_done) || (k - 1 < m_issue);
      if (was_idle && (ireq || dreq)) begin
        if (dreq && (!m_lastd || !ireq)) begin
          m_own = 1'b1; m_we = dwe; m_addr = daddr; m_wdata = dwdata;
        end else begin
          m_own = 1'b0; m_we = 1'b0; m_addr = iaddr; m_wdata = 32'h0;
        end
        m_issue = k;
        m_done  = k + W2;
        if (m_we) begin
          model_mem[m_addr[9:2]] = m_wdata;
          m_rdval = 32'h0;
        end else begin
          m_rdval = model_mem[m_addr[9:2]];
        end
      end
    end
  end

  // WAIT=1 memory: answers the cycle after the strobe.
  always @(posedge clk)
    mrdata1 <= mreq1 ? ((maddr1 == 32'h200) ? 32'h0000_1234 : 32'h0F0F_0000) : 32'hBAD1_BAD1;

  // Compare the WAIT=2 instance against the model every cycle.
  always @(negedge clk) begin
    logic        e_mreq, e_mwe, e_ir, e_dr, e_busy, skip_wd;
    logic [31:0] e_maddr, e_mwd, e_ird, e_drd;
    if (chk_en) begin
      skip_wd = 1'b0;
      if (!reset) begin
        e_mreq = 0; e_mwe = 0; e_ir = 0; e_dr = 0; e_busy = 0;
        e_maddr = 0; e_mwd = 0; e_ird = 0; e_drd = 0;
      end else begin
        e_busy  = (cyc >= m_issue) && (cyc <= m_done);
        e_mreq  = (cyc == m_issue);
        e_mwe   = e_mreq && m_we;
        e_maddr = e_mreq ? m_addr : 32'h0;
        e_mwd   = e_mwe ? m_wdata : 32'h0;
        skip_wd = e_mreq && !m_we;
        e_ir    = (cyc == m_done) && !m_own;
        e_dr    = (cyc == m_done) && m_own;
        e_ird   = e_ir ? m_rdval : m_ihold;
        e_drd   = (e_dr && !m_we) ? m_rdval : m_dhold;
      end
      check1("cyc_mreq", mreq, e_mreq);
      check1("cyc_mwe", mwe, e_mwe);
      check32("cyc_maddr", maddr, e_maddr);
      if (!skip_wd) check32("cyc_mwdata", mwdata, e_mwd);
      check1("cyc_iready", iready, e_ir);
      check1("cyc_dready", dready, e_dr);
      check32("cyc_irdata", irdata, e_ird);
      check32("cyc_drdata", drdata, e_drd);
      check1("cyc_busy", busy, e_busy);
    end
  end

  // Per-window observation log, indexed by cycle relative to the request cycle.
  logic [63:0] lg_ir, lg_dr, lg_mq;
  logic [31:0] lg_maddr, lg_mwdata, lg_rd;
  logic        lg_mwe;

  function automatic int first_set(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int count_set(input logic [63:0] v);
    int c = 0;
    for (int i = 0; i < 64; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input bit sel, input int n, input bit autodrop, input bit renew,
                         input int drop_at);
    bit got_mq, got_rdy;
    lg_ir = '0; lg_dr = '0; lg_mq = '0;
    lg_maddr = 0; lg_mwdata = 0; lg_rd = 0; lg_mwe = 0;
    got_mq = 0; got_rdy = 0;
    for (int r = 1; r <= n; r++) begin
      logic        o_ir, o_dr, o_mq, o_mwe;
      logic [31:0] o_ma, o_md, o_ird, o_drd;
      tick();
      if (sel) begin
        o_ir = iready1; o_dr = dready1; o_mq = mreq1; o_mwe = mwe1;
        o_ma = maddr1; o_md = mwdata1; o_ird = irdata1; o_drd = drdata1;
      end else begin
        o_ir = iready; o_dr = dready; o_mq = mreq; o_mwe = mwe;
        o_ma = maddr; o_md = mwdata; o_ird = irdata; o_drd = drdata;
      end
      lg_ir[r] = o_ir; lg_dr[r] = o_dr; lg_mq[r] = o_mq;
      if (o_mq && !got_mq) begin
        got_mq = 1; lg_maddr = o_ma; lg_mwe = o_mwe; lg_mwdata = o_md;
      end
      if ((o_ir || o_dr) && !got_rdy) begin
        got_rdy = 1; lg_rd = o_ir ? o_ird : o_drd;
      end
      if (r == drop_at) ireq = 1'b0;
      if (autodrop) begin
        if (sel) begin
          if (o_dr) dreq1 = 1'b0;
        end else begin
          if (o_ir) ireq = 1'b0;
          if (o_dr) dreq = 1'b0;
        end
      end
      if (renew && !sel) begin
        if (o_ir) iaddr = iaddr + 32'd4;
        if (o_dr) daddr = daddr + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ireq = 0; iaddr = 0; dreq = 0; dwe = 0; daddr = 0; dwdata = 0;
    dreq1 = 0; daddr1 = 0;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick();
    check1("reset_busy", busy, 1'b0);
    check1("reset_mreq", mreq, 1'b0);
    check32("reset_irdata", irdata, 32'h0);
    tick();
    reset = 1'b1;

    // Single fetch.
    tick();
    ireq = 1'b1; iaddr = 32'h40;
    observe(0, 8, 1, 0, 0);
    check32("A_mreq_cycle", first_set(lg_mq), 1);
    check32("A_maddr", lg_maddr, 32'h40);
    check1("A_mwe", lg_mwe, 1'b0);
    check32("A_iready_cycle", first_set(lg_ir), 3);
    check32("A_iready_count", count_set(lg_ir), 1);
    check32("A_mreq_count", count_set(lg_mq), 1);
    check32("A_irdata_pulse", lg_rd, 32'h8C01_0004);
    check32("A_irdata_held", irdata, 32'h8C01_0004);

    // Single data write.
    tick();
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hDEAD_BEEF;
    observe(0, 8, 1, 0, 0);
    dwe = 1'b0;
    check32("B_mreq_cycle", first_set(lg_mq), 1);
    check1("B_mwe", lg_mwe, 1'b1);
    check32("B_maddr", lg_maddr, 32'h100);
    check32("B_mwdata", lg_mwdata, 32'hDEAD_BEEF);
    check32("B_dready_cycle", first_set(lg_dr), 3);
    check32("B_mreq_count", count_set(lg_mq), 1);
    check32("B_drdata", drdata, 32'h0);

    // Both sides requesting continuously: strict alternation starting with D.
    do_reset();
    tick();
    ireq = 1'b1; iaddr = 32'h40;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h104;
    observe(0, 24, 0, 1, 0);
    ireq = 1'b0; dreq = 1'b0;
    check32("C_dready_mask", 32'(lg_dr), 32'h0008_0808);
    check32("C_iready_mask", 32'(lg_ir), 32'h0080_8080);
    check32("C_mreq_mask", 32'(lg_mq), 32'h0022_2222);
    check32("C_first_rdata", lg_rd, 32'hA500_0104);
    tick(); tick();

    // Reset during the wait phase of a fetch.
    tick();
    ireq = 1'b1; iaddr = 32'h44;
    tick(); tick();
    reset = 1'b0;
    #1;
    check1("E_busy_async", busy, 1'b0);
    check1("E_mreq_async", mreq, 1'b0);
    check32("E_irdata_async", irdata, 32'h0);
    ireq = 1'b0;
    observe(0, 4, 1, 0, 0);
    check32("E_no_iready", count_set(lg_ir), 0);
    reset = 1'b1;
    tick();
    ireq = 1'b1; iaddr = 32'h48;
    observe(0, 8, 1, 0, 0);
    check32("E_iready_cycle", first_set(lg_ir), 3);
    check32("E_rdata", lg_rd, 32'hA500_0048);

    // Request dropped right after being latched.
    tick();
    ireq = 1'b1; iaddr = 32'h4C;
    observe(0, 10, 1, 0, 1);
    check32("F_iready_cycle", first_set(lg_ir), 3);
    check32("F_iready_count", count_set(lg_ir), 1);
    check32("F_mreq_count", count_set(lg_mq), 1);
    check32("F_rdata", lg_rd, 32'hA500_004C);

    // WAIT=1 instance: single read, then back-to-back throughput.
    tick();
    dreq1 = 1'b1; daddr1 = 32'h200;
    observe(1, 6, 1, 0, 0);
    check32("G_mreq_cycle", first_set(lg_mq), 1);
    check32("G_dready_cycle", first_set(lg_dr), 2);
    check32("G_rdata", lg_rd, 32'h0000_1234);
    check32("G_drdata_held", drdata1, 32'h0000_1234);
    tick();
    dreq1 = 1'b1;
    observe(1, 12, 0, 0, 0);
    dreq1 = 1'b0;
    check32("G_mreq_mask", 32'(lg_mq), 32'h0000_0492);
    check32("G_dready_mask", 32'(lg_dr), 32'h0000_0924);
    tick(); tick();
    check1("G_idle", busy1, 1'b0);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
